// File: rtl/mdu_seq_ctrl_if.sv
// mdu_seq_ctrl_if: the pipeline-side bundle of the multiply/divide sequencer.
//   master : EX stage / hazard unit (drives requests, operands and MT writes)
//   slave  : mdu_seq_ctrl (drives busy/stall/done and the HI/LO registers)
// Signals:
//   start_i, op_i, rs_i, rt_i    mult/div request and forwarded operands
//   hi_we_i, lo_we_i, wdata_i    MTHI/MTLO writes
//   hilo_rd_i                    MFHI/MFLO in EX
//   flush_i                      EX instruction squashed
//   busy_o, stall_o, done_o      sequencer status
//   hi_o, lo_o                   committed HI/LO
interface mdu_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] wdata_i;
    logic             hilo_rd_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, hi_we_i, lo_we_i, wdata_i, hilo_rd_i, flush_i,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, hi_we_i, lo_we_i, wdata_i, hilo_rd_i, flush_i,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// Runs a 1-bit/cycle shift-add multiplier or restoring divider on operand magnitudes,
// fixes up signs in a final cycle and commits the result to the HI/LO registers it owns.
// Also serves MTHI/MTLO writes and raises a stall while a result is pending.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mdu_seq_ctrl_if.slave (requests, operands, MT writes, flush, status, HI/LO)
// Optional feature macro: MDU_EARLY_TERM_EN (multiplies finish as soon as the remaining
// multiplier bits are all zero; division is unaffected).
module mdu_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Mult: {partial product high, multiplier / product low}. Div: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude (mult) or divisor magnitude (div).
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MDU_EARLY_TERM_EN
    logic [WIDTH-1:0]   ones;
    logic [WIDTH-1:0]   rest_mask;
    logic               mul_rest_zero;
`endif

    // Operand magnitudes; only signed ops (op_i[0]==0) take absolute values.
    assign signed_op = ~bus.op_i[0];
    assign rs_neg    = signed_op & bus.rs_i[WIDTH-1];
    assign rt_neg    = signed_op & bus.rt_i[WIDTH-1];
    assign rs_abs    = rs_neg ? -bus.rs_i : bus.rs_i;
    assign rt_abs    = rt_neg ? -bus.rt_i : bus.rt_i;

    // Shift-add step: add multiplicand to the high half when the multiplier LSB is set,
    // then shift the whole accumulator right by one (carry enters at the top).
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift {rem,quo} left, subtract the divisor if it fits.
    // The shifted remainder needs WIDTH+1 bits before the compare.
    assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff   = div_rem_sh - {1'b0, opa_q};
    assign div_next   = {(div_diff[WIDTH] ? div_rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_TERM_EN
    // After this step cnt_q multiplier bits remain unshifted, in the low cnt_q positions.
    assign ones          = '1;
    assign rest_mask     = ~(ones << cnt_q);
    assign mul_rest_zero = (mul_next[WIDTH-1:0] & rest_mask) == '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.flush_i) begin
                    if (bus.start_i) begin
                        // Start wins over a simultaneous MT write.
                        is_div_d  = bus.op_i[1];
                        neg_res_d = rs_neg ^ rt_neg;
                        neg_rem_d = rs_neg;
                        div0_d    = 1'b0;
                        cnt_d     = CntLoad;
                        opa_d     = bus.op_i[1] ? rt_abs : rs_abs;
                        acc_d     = {{WIDTH{1'b0}}, (bus.op_i[1] ? rs_abs : rt_abs)};
                        state_d   = StCalc;
                        if (bus.op_i[1] && (bus.rt_i == '0)) begin
                            // Divide by zero: HI gets the raw dividend.
                            div0_d  = 1'b1;
                            acc_d   = {{WIDTH{1'b0}}, bus.rs_i};
                            state_d = StFix;
                        end
`ifdef MDU_EARLY_TERM_EN
                        if (!bus.op_i[1] && (bus.rt_i == '0)) begin
                            state_d = StFix;
                        end
`endif
                    end else begin
                        if (bus.hi_we_i) begin
                            hi_d = bus.wdata_i;
                        end
                        if (bus.lo_we_i) begin
                            lo_d = bus.wdata_i;
                        end
                    end
                end
            end
            StCalc: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
`ifdef MDU_EARLY_TERM_EN
                        if (!is_div_q && mul_rest_zero) begin
                            // Remaining steps would only shift; do all of them at once.
                            acc_d   = mul_next >> cnt_q;
                            cnt_d   = '0;
                            state_d = StFix;
                        end
`endif
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!bus.flush_i) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.stall_o = busy_q & (bus.start_i | bus.hilo_rd_i | bus.hi_we_i | bus.lo_we_i);

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: directed self-checking bench for mdu_seq_ctrl (WIDTH=32).
module tb_mdu_seq_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mdu_seq_ctrl_if #(.WIDTH(32)) bus ();

    mdu_seq_ctrl #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.op_i    = op;
        bus.rs_i    = rs;
        bus.rt_i    = rt;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    // Counts edges after the start edge until done_o, and cycles with busy_o high.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = bus.busy_o ? 1 : 0;
        while (cyc < 100 && !bus.done_o) begin
            step();
            cyc++;
            if (bus.busy_o) bcnt++;
        end
        chk("done_seen", {63'd0, bus.done_o}, 64'd1);
    endtask

    int cyc;
    int bcnt;
    int scnt;
    int lat;
    logic seen_done;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start_i   = 1'b0;
        bus.op_i      = 2'b00;
        bus.rs_i      = '0;
        bus.rt_i      = '0;
        bus.hi_we_i   = 1'b0;
        bus.lo_we_i   = 1'b0;
        bus.wdata_i   = '0;
        bus.hilo_rd_i = 1'b0;
        bus.flush_i   = 1'b0;
        #12;
        chk("rst_busy",  {63'd0, bus.busy_o},  64'd0);
        chk("rst_done",  {63'd0, bus.done_o},  64'd0);
        chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
        chk("rst_hi",    {32'd0, bus.hi_o},    64'd0);
        chk("rst_lo",    {32'd0, bus.lo_o},    64'd0);
        rst_n = 1'b1;
        step();

        // MULT -3 * 7 = -21
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bcnt);
`ifdef MDU_EARLY_TERM_EN
        lat = 4;
`else
        lat = 33;
`endif
        chk("mult_lat",  64'(cyc),  64'(lat));
        chk("mult_busy", 64'(bcnt), 64'(lat));
        chk("mult_hi", {32'd0, bus.hi_o}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, bus.lo_o}, 64'hFFFF_FFEB);
        step();
        chk("done_pulse", {63'd0, bus.done_o}, 64'd0);

        // DIVU 100 / 7
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(cyc, bcnt);
        chk("divu_lat", 64'(cyc), 64'd33);
        chk("divu_lo", {32'd0, bus.lo_o}, 64'd14);
        chk("divu_hi", {32'd0, bus.hi_o}, 64'd2);

        // DIV -100 / 7 with an MTHI presented while busy (must stall and be ignored)
        start_op(2'b10, 32'hFFFF_FF9C, 32'd7);
        step();
        step();
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'h55;
        #1;
        chk("mt_busy_stall", {63'd0, bus.stall_o}, 64'd1);
        wait_done(cyc, bcnt);
        chk("div_lo", {32'd0, bus.lo_o}, 64'hFFFF_FFF2);
        chk("div_hi", {32'd0, bus.hi_o}, 64'hFFFF_FFFE);
        bus.hi_we_i = 1'b0;
        step();

        // DIV by zero
        start_op(2'b10, 32'h1234_5678, 32'd0);
        wait_done(cyc, bcnt);
        chk("dz_lat",  64'(cyc),  64'd1);
        chk("dz_busy", 64'(bcnt), 64'd1);
        chk("dz_hi", {32'd0, bus.hi_o}, 64'h1234_5678);
        chk("dz_lo", {32'd0, bus.lo_o}, 64'hFFFF_FFFF);

        // Signed overflow: 0x80000000 / -1
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bcnt);
        chk("ovf_lo", {32'd0, bus.lo_o}, 64'h8000_0000);
        chk("ovf_hi", {32'd0, bus.hi_o}, 64'd0);

        // MULTU max * max
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bcnt);
        chk("multu_lat", 64'(cyc), 64'd33);
        chk("multu_hi", {32'd0, bus.hi_o}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, bus.lo_o}, 64'h0000_0001);

        // MULTU with MFHI arriving at cycle 4 after start: stall until IDLE
        start_op(2'b01, 32'h0001_0000, 32'h0001_0000);
        step();
        step();
        step();
        step();
        bus.hilo_rd_i = 1'b1;
        #1;
        chk("rd_stall_on", {63'd0, bus.stall_o}, 64'd1);
        scnt = 1;
        cyc  = 4;
        while (cyc < 100 && !bus.done_o) begin
            step();
            cyc++;
            if (bus.stall_o) scnt++;
        end
`ifdef MDU_EARLY_TERM_EN
        lat = 18;
`else
        lat = 33;
`endif
        chk("rd_done",      {63'd0, bus.done_o},  64'd1);
        chk("rd_stall_cnt", 64'(scnt),            64'(lat - 4));
        chk("rd_stall_off", {63'd0, bus.stall_o}, 64'd0);
        chk("rd_hi", {32'd0, bus.hi_o}, 64'd1);
        chk("rd_lo", {32'd0, bus.lo_o}, 64'd0);
        bus.hilo_rd_i = 1'b0;
        step();

        // MTHI/MTLO in the same cycle
        bus.hi_we_i = 1'b1;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hA;
        bus.lo_we_i = 1'b0;
        step();
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hB;
        step();
        bus.lo_we_i = 1'b0;
        chk("mthi", {32'd0, bus.hi_o}, 64'hA);
        chk("mtlo", {32'd0, bus.lo_o}, 64'hB);
        bus.hi_we_i = 1'b1;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hC;
        step();
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        chk("mt_both_hi", {32'd0, bus.hi_o}, 64'hC);
        chk("mt_both_lo", {32'd0, bus.lo_o}, 64'hC);
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'hA;
        step();
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hB;
        step();
        bus.lo_we_i = 1'b0;

        // Start squashed in IDLE
        bus.flush_i = 1'b1;
        start_op(2'b11, 32'd1000, 32'd3);
        bus.flush_i = 1'b0;
        chk("idle_flush_busy", {63'd0, bus.busy_o}, 64'd0);

        // Flush at cycle 10 of a DIVU: abort, HI/LO preserved, no done
        start_op(2'b11, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("flush_hi", {32'd0, bus.hi_o}, 64'hA);
        chk("flush_lo", {32'd0, bus.lo_o}, 64'hB);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen_done = seen_done | bus.done_o;
        end
        chk("flush_no_done", {63'd0, seen_done}, 64'd0);

        // Async reset in the middle of CALC
        start_op(2'b11, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("arst_hi", {32'd0, bus.hi_o}, 64'd0);
        chk("arst_lo", {32'd0, bus.lo_o}, 64'd0);
        #2;
        rst_n = 1'b1;
        step();

        // MULTU rt=1: early termination finishes in 2 cycles, otherwise the full run
        start_op(2'b01, 32'h0000_1234, 32'd1);
        wait_done(cyc, bcnt);
`ifdef MDU_EARLY_TERM_EN
        lat = 2;
`else
        lat = 33;
`endif
        chk("one_lat", 64'(cyc), 64'(lat));
        chk("one_lo", {32'd0, bus.lo_o}, 64'h1234);
        chk("one_hi", {32'd0, bus.hi_o}, 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
